// File: rtl/card_pkg.sv
// Shared constants, state encoding and deck indexing for the card dealer.
package card_pkg;

  localparam int          RANK_MAX   = 12;
  localparam int          DECK_SIZE  = 52;
  localparam int          NUM_SLOTS  = 5;
  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // Galois right-shift taps for x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [5:0] deck_index(input logic [1:0] suit, input logic [3:0] rank);
    return ({4'd0, suit} * 6'd13) + {2'd0, rank};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with seed load; a zero seed loads the reset value.
module lfsr16
  import card_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [5:0]  low_bits
);

  logic [15:0] value_q;
  logic [15:0] value_d;

  always_comb begin
    value_d = {1'b0, value_q[15:1]} ^ (value_q[0] ? LFSR_TAPS : 16'h0000);
    if (load) begin
      value_d = (seed == 16'h0000) ? LFSR_RESET : seed;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= LFSR_RESET;
    end else begin
      value_q <= value_d;
    end
  end

  assign low_bits = value_q[5:0];

endmodule

// File: rtl/card_dealer.sv
// Deals a 5-card hand without replacement from a 52-card deck, with hold/redraw.
module card_dealer
  import card_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redraw,
  input  logic [4:0]  hold,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [3:0]  card1,
  output logic [3:0]  card2,
  output logic [3:0]  card3,
  output logic [3:0]  card4,
  output logic [3:0]  card5,
  output logic [1:0]  suit1,
  output logic [1:0]  suit2,
  output logic [1:0]  suit3,
  output logic [1:0]  suit4,
  output logic [1:0]  suit5,
  output logic        valid,
  output logic        busy
);

  logic [5:0] lfsr_low;

  lfsr16 u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (seed_load),
    .seed     (seed),
    .low_bits (lfsr_low)
  );

  state_t                 state_q, state_d;
  logic [DECK_SIZE-1:0]   used_q, used_d;
  logic [NUM_SLOTS-1:0]   pending_q, pending_d;
  logic [3:0]             rank_q [NUM_SLOTS];
  logic [3:0]             rank_d [NUM_SLOTS];
  logic [1:0]             suit_q [NUM_SLOTS];
  logic [1:0]             suit_d [NUM_SLOTS];
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic [3:0] cand_rank;
  logic [1:0] cand_suit;
  logic [5:0] cand_idx;
  logic       cand_ok;
  logic [2:0] slot_sel;

  assign cand_rank = lfsr_low[3:0];
  assign cand_suit = lfsr_low[5:4];
  assign cand_idx  = deck_index(cand_suit, cand_rank);
  assign cand_ok   = (cand_rank <= 4'(RANK_MAX)) && !used_q[cand_idx];

  // Lowest-numbered pending slot is filled first.
  always_comb begin
    slot_sel = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        slot_sel = 3'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    used_d    = used_q;
    pending_d = pending_q;
    rank_d    = rank_q;
    suit_d    = suit_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = DRAW;
          used_d    = '0;
          pending_d = '1;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
        end
      end
      DRAW: begin
        if (pending_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end else if (cand_ok) begin
          rank_d[slot_sel]    = cand_rank;
          suit_d[slot_sel]    = cand_suit;
          used_d[cand_idx]    = 1'b1;
          pending_d[slot_sel] = 1'b0;
        end
      end
      DONE: begin
        if (start) begin
          state_d   = DRAW;
          used_d    = '0;
          pending_d = '1;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
        end else if (redraw) begin
          // Used mask is kept so discarded cards cannot come back this round.
          state_d   = DRAW;
          pending_d = ~hold;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      used_q    <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        rank_q[i] <= '0;
        suit_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      used_q    <= used_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      rank_q    <= rank_d;
      suit_q    <= suit_d;
    end
  end

  assign card1 = rank_q[0];
  assign card2 = rank_q[1];
  assign card3 = rank_q[2];
  assign card4 = rank_q[3];
  assign card5 = rank_q[4];
  assign suit1 = suit_q[0];
  assign suit2 = suit_q[1];
  assign suit3 = suit_q[2];
  assign suit4 = suit_q[3];
  assign suit5 = suit_q[4];
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: requests push expectations, a monitor checks each completed hand.
module tb_card_dealer;

  logic        clk = 1'b0;
  logic        rst, start, redraw, seed_load, valid, busy;
  logic [4:0]  hold;
  logic [15:0] seed;
  logic [3:0]  card1, card2, card3, card4, card5;
  logic [1:0]  suit1, suit2, suit3, suit4, suit5;

  always #5 clk = ~clk;

  card_dealer dut (
    .clk(clk), .rst(rst), .start(start), .redraw(redraw), .hold(hold),
    .seed_load(seed_load), .seed(seed),
    .card1(card1), .card2(card2), .card3(card3), .card4(card4), .card5(card5),
    .suit1(suit1), .suit2(suit2), .suit3(suit3), .suit4(suit4), .suit5(suit5),
    .valid(valid), .busy(busy)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  typedef enum int {K_FRESH, K_REDRAW, K_HOLDALL, K_EXACT} kind_e;
  typedef struct {
    kind_e       kind;
    logic [29:0] prior;
    logic [4:0]  hold;
    logic [29:0] exact;
    string       tag;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks_total++;
    if (act === req) checks_passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Slot i occupies bits [6i+:6] as {suit, rank}.
  function automatic logic [29:0] cur_hand();
    return {suit5, card5, suit4, card4, suit3, card3, suit2, card2, suit1, card1};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Hand expected when seed is loaded at edge E and start is accepted at edge E+1.
  function automatic logic [29:0] model_deal(input logic [15:0] s);
    logic [15:0] v;
    logic [63:0] used;
    logic [29:0] h;
    int          idx;
    v    = lfsr_step((s == 16'h0000) ? 16'hACE1 : s);
    used = '0;
    h    = '0;
    for (int slot = 0; slot < 5; slot++) begin
      for (int tries = 0; tries < 1000; tries++) begin
        idx = int'(v[5:4]) * 13 + int'(v[3:0]);
        if (v[3:0] <= 4'd12 && !used[idx]) begin
          used[idx]       = 1'b1;
          h[6*slot +: 6]  = v[5:0];
          v               = lfsr_step(v);
          break;
        end
        v = lfsr_step(v);
      end
    end
    return h;
  endfunction

  function automatic int bad_ranks(input logic [29:0] h);
    int n = 0;
    for (int i = 0; i < 5; i++) if (h[6*i +: 4] > 4'd12) n++;
    return n;
  endfunction

  function automatic int dup_pairs(input logic [29:0] h);
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = i + 1; j < 5; j++)
        if (h[6*i +: 6] == h[6*j +: 6]) n++;
    return n;
  endfunction

  // Monitor: each rising valid completes exactly one queued request.
  initial begin
    logic        vprev;
    logic [29:0] h;
    exp_t        e;
    int          held_diff, collide;
    vprev = 1'b0;
    forever begin
      @(negedge clk);
      if (valid && !vprev) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          h = cur_hand();
          case (e.kind)
            K_FRESH: begin
              check({e.tag, "_ranks"}, bad_ranks(h), 0);
              check({e.tag, "_distinct"}, dup_pairs(h), 0);
            end
            K_REDRAW: begin
              held_diff = 0;
              collide   = 0;
              for (int i = 0; i < 5; i++) begin
                if (e.hold[i]) begin
                  if (h[6*i +: 6] != e.prior[6*i +: 6]) held_diff++;
                end else begin
                  for (int j = 0; j < 5; j++) if (h[6*i +: 6] == e.prior[6*j +: 6]) collide++;
                  for (int j = 0; j < 5; j++) if (j != i && !e.hold[j] && h[6*i +: 6] == h[6*j +: 6]) collide++;
                end
              end
              check({e.tag, "_held_kept"}, held_diff, 0);
              check({e.tag, "_new_distinct"}, collide, 0);
              check({e.tag, "_ranks"}, bad_ranks(h), 0);
            end
            K_HOLDALL: check({e.tag, "_unchanged"}, {2'b0, h}, {2'b0, e.prior});
            default:   check({e.tag, "_hand"}, {2'b0, h}, {2'b0, e.exact});
          endcase
        end
      end
      vprev = valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid_in_200"}, {31'd0, valid}, 32'd1);
  endtask

  task automatic push(input kind_e k, input logic [4:0] hm, input logic [29:0] ex, input string tag);
    exp_t e;
    e.kind  = k;
    e.prior = cur_hand();
    e.hold  = hm;
    e.exact = ex;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic seeded_deal(input logic [15:0] s, input string tag, input bit inject);
    seed = s; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b1;
    push(K_EXACT, 5'b0, model_deal(s), tag);
    tick();
    start = 1'b0;
    check({tag, "_busy_n1"}, {31'd0, busy}, 32'd1);
    if (inject) begin
      start = 1'b1; redraw = 1'b1; hold = 5'b00000;
      tick();
      start = 1'b0; redraw = 1'b0;
      check({tag, "_still_busy"}, {31'd0, busy}, 32'd1);
    end
    wait_valid(tag);
  endtask

  initial begin
    logic [29:0] run1;
    rst = 1'b1; start = 1'b0; redraw = 1'b0; hold = 5'b0; seed_load = 1'b0; seed = 16'h0;
    repeat (2) tick();
    check("reset_cards", {2'b0, cur_hand()}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_busy",  {31'd0, busy}, 32'd0);
    check("reset_lfsr",  {16'd0, dut.u_lfsr.value_q}, 32'h0000ACE1);
    rst = 1'b0;

    redraw = 1'b1; hold = 5'b00000;
    tick();
    redraw = 1'b0;
    check("idle_redraw_busy",  {31'd0, busy}, 32'd0);
    check("idle_redraw_valid", {31'd0, valid}, 32'd0);

    push(K_FRESH, 5'b0, 30'd0, "deal1");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("deal1_busy_n1",  {31'd0, busy}, 32'd1);
    check("deal1_valid_n1", {31'd0, valid}, 32'd0);
    wait_valid("deal1");

    hold = 5'b10101;
    push(K_REDRAW, hold, 30'd0, "redraw10101");
    redraw = 1'b1;
    tick();
    redraw = 1'b0;
    check("redraw_busy_n1", {31'd0, busy}, 32'd1);
    wait_valid("redraw10101");

    hold = 5'b11111;
    push(K_HOLDALL, hold, 30'd0, "holdall");
    redraw = 1'b1;
    tick();
    redraw = 1'b0;
    check("holdall_valid_n1", {31'd0, valid}, 32'd0);
    check("holdall_busy_n1",  {31'd0, busy}, 32'd1);
    tick();
    check("holdall_valid_n2", {31'd0, valid}, 32'd1);
    check("holdall_busy_n2",  {31'd0, busy}, 32'd0);

    seed = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("seed_zero_lfsr", {16'd0, dut.u_lfsr.value_q}, 32'h0000ACE1);

    seeded_deal(16'h1234, "seed1234_a", 1'b0);
    run1 = cur_hand();
    seeded_deal(16'h1234, "seed1234_b", 1'b0);
    check("seed1234_repeat", {2'b0, cur_hand()}, {2'b0, run1});

    // Start wins over a hold-all redraw: a fresh deal cannot finish by N+2.
    seed = 16'hBEEF; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b1; redraw = 1'b1; hold = 5'b11111;
    push(K_EXACT, 5'b0, model_deal(16'hBEEF), "start_prio");
    tick();
    start = 1'b0; redraw = 1'b0;
    tick();
    check("start_prio_valid_n2", {31'd0, valid}, 32'd0);
    wait_valid("start_prio");

    seeded_deal(16'h5A5A, "busy_ignore", 1'b1);

    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_cards", {2'b0, cur_hand()}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_busy",  {31'd0, busy}, 32'd0);
    check("midrst_lfsr",  {16'd0, dut.u_lfsr.value_q}, 32'h0000ACE1);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
